// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver with a double-buffered display image.
// A pending image is accepted by ready/load and copied to the active image only at frame boundaries.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 16666667
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink,
  output logic        ready,
  output logic [3:0]  an,
  output logic [6:0]  out
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef struct packed {
    logic [15:0] din;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } img_t;

  localparam img_t RST_IMG = '{din: 16'h0000, blank: 4'hF, blink: 4'h0};

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [1:0]         r_idx;
  logic               r_phase;
  img_t               r_pend;
  img_t               r_act;
  logic               r_pend_vld;
  logic [3:0]         r_an;
  logic [6:0]         r_out;

  logic               w_tick;
  logic               w_frame;
  logic               w_blink_wrap;
  logic               w_accept;
  logic               w_commit;
  logic [3:0]         w_digit;
  logic               w_dark;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_tick       = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_frame      = w_tick && (r_idx == 2'd3);
  assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
  // Accept and commit are mutually exclusive: one needs the pending slot empty, the other full.
  assign w_accept     = load && !r_pend_vld;
  assign w_commit     = w_frame && r_pend_vld;

  assign w_digit = r_act.din[r_idx*4 +: 4];
  assign w_dark  = r_act.blank[r_idx] | (r_act.blink[r_idx] & r_phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_blink_cnt <= '0;
      r_idx       <= 2'd0;
      r_phase     <= 1'b0;
      r_pend      <= '0;
      r_pend_vld  <= 1'b0;
      r_act       <= RST_IMG;
      r_an        <= 4'hF;
      r_out       <= 7'h7F;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
      if (w_tick) r_idx <= r_idx + 2'd1;

      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
      if (w_blink_wrap) r_phase <= ~r_phase;

      if (w_accept) begin
        r_pend     <= '{din: din, blank: blank, blink: blink};
        r_pend_vld <= 1'b1;
      end
      if (w_commit) begin
        r_act      <= r_pend;
        r_pend_vld <= 1'b0;
      end

      // Outputs follow the current slot state, so they lag idx/phase/active by one cycle.
      r_an  <= ~(4'b0001 << r_idx);
      r_out <= w_dark ? 7'h7F : seg_decode(w_digit);
    end
  end

  assign ready = ~r_pend_vld;
  assign an    = r_an;
  assign out   = r_out;

endmodule
